// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: instruction and status
// codes, the FSM state type, the latched request record and small decode
// helpers shared by the stage and its sub-blocks.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [63:0] val_p;
        logic        instr_valid;
        logic        imem_error;
    } mem_req_t;

    // Instructions that store 8 bytes to data memory.
    function automatic logic is_write_op(input logic [3:0] icode);
        logic r;
        case (icode)
            IRMMOVQ, ICALL, IPUSHQ: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions that load 8 bytes from data memory.
    function automatic logic is_read_op(input logic [3:0] icode);
        logic r;
        case (icode)
            IMRMOVQ, IRET, IPOPQ: r = 1'b1;
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

    // Stack pops take their address from the old stack pointer in ValA.
    function automatic logic addr_from_vala(input logic [3:0] icode);
        logic r;
        case (icode)
            IRET, IPOPQ: r = 1'b1;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    // Architectural status, highest priority first.
    function automatic logic [2:0] stat_code(input logic       imem_error,
                                             input logic       instr_valid,
                                             input logic       dmem_error,
                                             input logic [3:0] icode);
        logic [2:0] s;
        if (imem_error) begin
            s = SADR;
        end else if (!instr_valid) begin
            s = SINS;
        end else if (dmem_error) begin
            s = SADR;
        end else if (icode == IHALT) begin
            s = SHLT;
        end else begin
            s = SAOK;
        end
        return s;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/response bundle between the sequencer (master) and the memory
// stage (slave). Port names follow the Y86 datapath signal names.
interface mem_stage_if;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] ValE;
    logic [63:0] ValA;
    logic [63:0] ValP;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] ValM;
    logic        dmem_error;
    logic [2:0]  stat;
    logic        busy;
    logic        done;

    modport master (
        output start, icode, ValE, ValA, ValP, instr_valid, imem_error,
        input  ValM, dmem_error, stat, busy, done
    );

    modport slave (
        input  start, icode, ValE, ValA, ValP, instr_valid, imem_error,
        output ValM, dmem_error, stat, busy, done
    );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Byte-addressed data memory: combinational 8-byte little-endian read and
// a synchronous 8-byte write. The caller guarantees addr+7 < DEPTH.
// Contents start at zero and are never cleared afterwards.
module data_mem #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

    // Assemble the 8-byte read word, lowest address in the LSB.
    always_comb begin
        rdata = 64'h0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem_q[addr + AW'(i)];
        end
    end

    // Store all eight bytes together on a write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[addr + AW'(i)] <= wdata[8*i +: 8];
            end
        end else begin
            // no write this cycle
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 SEQ memory stage. A start pulse latches the request; after LAT
// cycles the access is performed, results are registered and done pulses.
// The range check uses the full 64-bit address so huge values cannot wrap
// into the array. LAT must lie in 1..15.
module mem_stage
    import y86_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned LAT   = 1
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LAT - 1);
    localparam logic [63:0] ADDR_MAX = 64'(DEPTH - 8);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [63:0] valm_q, valm_d;
    logic        dmem_error_q, dmem_error_d;
    logic [2:0]  stat_q, stat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [63:0]   addr_s;
    logic [63:0]   wdata_s;
    logic [63:0]   rdata_s;
    logic [63:0]   valm_res_s;
    logic [2:0]    stat_res_s;
    logic [AW-1:0] mem_addr_s;
    logic          mem_op_s;
    logic          range_err_s;
    logic          suppress_s;
    logic          access_ok_s;
    logic          finish_s;
    logic          we_s;

    // Decode the latched request into address, data and access qualifiers.
    always_comb begin
        addr_s      = addr_from_vala(req_q.icode) ? req_q.val_a : req_q.val_e;
        wdata_s     = (req_q.icode == ICALL) ? req_q.val_p : req_q.val_a;
        mem_op_s    = is_write_op(req_q.icode) || is_read_op(req_q.icode);
        range_err_s = mem_op_s && (addr_s > ADDR_MAX);
        suppress_s  = req_q.imem_error || !req_q.instr_valid;
        access_ok_s = mem_op_s && !range_err_s && !suppress_s;
        mem_addr_s  = access_ok_s ? addr_s[AW-1:0] : {AW{1'b0}};
        valm_res_s  = (access_ok_s && is_read_op(req_q.icode)) ? rdata_s : 64'h0;
        stat_res_s  = stat_code(req_q.imem_error, req_q.instr_valid,
                                range_err_s, req_q.icode);
        finish_s    = (state_q == S_WAIT) && (cnt_q == 4'd0);
        we_s        = finish_s && !reset && access_ok_s && is_write_op(req_q.icode);
    end

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk   (clk),
        .we    (we_s),
        .addr  (mem_addr_s),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // Next-state logic: accept a request in IDLE, count down in WAIT, finish at zero.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        valm_d       = valm_q;
        dmem_error_d = dmem_error_q;
        stat_d       = stat_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d           = S_WAIT;
                    cnt_d             = CNT_LOAD;
                    busy_d            = 1'b1;
                    req_d.icode       = bus.icode;
                    req_d.val_e       = bus.ValE;
                    req_d.val_a       = bus.ValA;
                    req_d.val_p       = bus.ValP;
                    req_d.instr_valid = bus.instr_valid;
                    req_d.imem_error  = bus.imem_error;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_WAIT: begin
                busy_d = 1'b1;
                if (finish_s) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    valm_d       = valm_res_s;
                    dmem_error_d = range_err_s;
                    stat_d       = stat_res_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any pending operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_q        <= '0;
            valm_q       <= 64'h0;
            dmem_error_q <= 1'b0;
            stat_q       <= SAOK;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            valm_q       <= valm_d;
            dmem_error_q <= dmem_error_d;
            stat_q       <= stat_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ValM       = valm_q;
    assign bus.dmem_error = dmem_error_q;
    assign bus.stat       = stat_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a reference model predicts each result
// when a request is issued; a monitor pops and compares on every done.
module tb_mem_stage;
    import y86_pkg::*;

    typedef struct {
        logic [63:0] valm;
        logic        dmem_error;
        logic [2:0]  stat;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_stage_if bus ();
    mem_stage_if bus4 ();

    mem_stage #(.DEPTH(1024), .LAT(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    mem_stage #(.DEPTH(1024), .LAT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    always #5 clk = ~clk;

    int         total_cnt = 0;
    int         bad_cnt   = 0;
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_mem [1024];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: predict result and update the model memory.
    task automatic push_expect(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                               input logic [63:0] vp, input logic iv, input logic ie);
        exp_t        e;
        logic [63:0] a;
        logic [63:0] d;
        bit          uses_mem, rd, wr, bad;
        uses_mem = 0; rd = 0; wr = 0; a = ve; d = va;
        case (ic)
            4'h4: begin uses_mem = 1; wr = 1; end
            4'h5: begin uses_mem = 1; rd = 1; end
            4'h8: begin uses_mem = 1; wr = 1; d = vp; end
            4'h9: begin uses_mem = 1; rd = 1; a = va; end
            4'hA: begin uses_mem = 1; wr = 1; end
            4'hB: begin uses_mem = 1; rd = 1; a = va; end
            default: ;
        endcase
        bad          = uses_mem && (a > 64'd1016);
        e.valm       = 64'h0;
        e.dmem_error = bad;
        if (ie)           e.stat = 3'd3;
        else if (!iv)     e.stat = 3'd4;
        else if (bad)     e.stat = 3'd3;
        else if (ic == 0) e.stat = 3'd2;
        else              e.stat = 3'd1;
        if (uses_mem && !bad && iv && !ie) begin
            for (int i = 0; i < 8; i++) begin
                if (wr) model_mem[int'(a[9:0]) + i] = d[8*i +: 8];
                if (rd) e.valm[8*i +: 8] = model_mem[int'(a[9:0]) + i];
            end
        end
        exp_q.push_back(e);
    endtask

    // Issue one request to the LAT=1 instance and wait (bounded) for done.
    task automatic do_op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                         input logic [63:0] vp, input logic iv = 1'b1, input logic ie = 1'b0);
        int waited;
        push_expect(ic, ve, va, vp, iv, ie);
        @(negedge clk);
        bus.start = 1'b1; bus.icode = ic; bus.ValE = ve; bus.ValA = va; bus.ValP = vp;
        bus.instr_valid = iv; bus.imem_error = ie;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_after_start", 64'(bus.busy), 64'd1);
        waited = 0;
        while (bus.done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("latency", 64'(waited), 64'd1);
        @(negedge clk);
    endtask

    // Monitor: every done of the LAT=1 instance is checked against the scoreboard.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("done_unexpected", 64'(bus.done), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("ValM", bus.ValM, mon_e.valm);
                check_val("dmem_error", 64'(bus.dmem_error), 64'(mon_e.dmem_error));
                check_val("stat", 64'(bus.stat), 64'(mon_e.stat));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        int waited;
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
        bus.start = 1'b0; bus.icode = 4'h0; bus.ValE = 64'h0; bus.ValA = 64'h0; bus.ValP = 64'h0;
        bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
        bus4.start = 1'b0; bus4.icode = 4'h0; bus4.ValE = 64'h0; bus4.ValA = 64'h0; bus4.ValP = 64'h0;
        bus4.instr_valid = 1'b1; bus4.imem_error = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_ValM", bus.ValM, 64'h0);
        check_val("rst_stat", 64'(bus.stat), 64'd1);
        check_val("rst_dmem", 64'(bus.dmem_error), 64'd0);
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst4_stat", 64'(bus4.stat), 64'd1);
        check_val("rst4_busy", 64'(bus4.busy), 64'd0);
        reset = 1'b0;

        // Basic store/load pairs.
        do_op(IRMMOVQ, 64'd2, 64'd120, 64'd0);
        do_op(IMRMOVQ, 64'd2, 64'd0, 64'd0);
        do_op(IPUSHQ, 64'h1F8, 64'hDEADBEEF, 64'd0);
        do_op(IPOPQ, 64'd0, 64'h1F8, 64'd0);
        do_op(ICALL, 64'h1F0, 64'd0, 64'd55);
        do_op(IRET, 64'd0, 64'h1F0, 64'd0);
        // Highest legal address, then first illegal one.
        do_op(IRMMOVQ, 64'd1016, 64'h1122334455667788, 64'd0);
        do_op(IMRMOVQ, 64'd1016, 64'd0, 64'd0);
        do_op(INOP, 64'd1016, 64'd1016, 64'd0);
        do_op(IRMMOVQ, 64'hFFFFFFFFFFFFFFFC, 64'hFFFF, 64'd0);
        do_op(IMRMOVQ, 64'd0, 64'd0, 64'd0);
        do_op(IMRMOVQ, 64'd1017, 64'd0, 64'd0);

        // Reset during WAIT aborts the write and clears the outputs.
        @(negedge clk);
        bus.start = 1'b1; bus.icode = IRMMOVQ; bus.ValE = 64'd8; bus.ValA = 64'd5;
        bus.instr_valid = 1'b1; bus.imem_error = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_val("abort_done", 64'(bus.done), 64'd0);
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_stat", 64'(bus.stat), 64'd1);
        check_val("abort_dmem", 64'(bus.dmem_error), 64'd0);
        check_val("abort_ValM", bus.ValM, 64'h0);
        // Reset and start together: the request is dropped.
        bus.start = 1'b1; bus.icode = IRMMOVQ; bus.ValE = 64'd16; bus.ValA = 64'd9;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        check_val("rststart_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_val("rststart_done", 64'(bus.done), 64'd0);
        do_op(IMRMOVQ, 64'd8, 64'd0, 64'd0);
        do_op(IMRMOVQ, 64'd16, 64'd0, 64'd0);

        // Status codes.
        do_op(IHALT, 64'd0, 64'd0, 64'd0);
        do_op(IRMMOVQ, 64'h40, 64'd7, 64'd0, 1'b0, 1'b0);
        do_op(IMRMOVQ, 64'h40, 64'd0, 64'd0);
        do_op(IMRMOVQ, 64'd2, 64'd0, 64'd0, 1'b1, 1'b1);
        do_op(IHALT, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);

        // Random mix of opcodes and addresses around the boundary.
        for (int k = 0; k < 24; k++) begin
            do_op(4'($urandom_range(0, 11)), 64'($urandom_range(0, 1030)),
                  64'($urandom_range(0, 1030)), {$urandom, $urandom},
                  1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0));
        end

        // LAT=4 timing; a second start while busy must be ignored.
        @(negedge clk);
        bus4.start = 1'b1; bus4.icode = INOP; bus4.ValE = 64'd0; bus4.ValA = 64'd0;
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) bus4.start = 1'b0;
            if (c == 1) begin
                bus4.start = 1'b1; bus4.icode = IRMMOVQ; bus4.ValE = 64'd0; bus4.ValA = 64'd99;
            end
            if (c == 2) bus4.start = 1'b0;
            check_val("lat4_done", 64'(bus4.done), 64'(c == 4));
            check_val("lat4_busy", 64'(bus4.busy), 64'(c <= 4));
            if (bus4.done === 1'b1) begin
                dn++;
                check_val("lat4_stat", 64'(bus4.stat), 64'd1);
            end
        end
        check_val("lat4_done_count", 64'(dn), 64'd1);
        // The ignored store must not have reached memory.
        @(negedge clk);
        bus4.start = 1'b1; bus4.icode = IMRMOVQ; bus4.ValE = 64'd0;
        @(negedge clk);
        bus4.start = 1'b0;
        waited = 0;
        while (bus4.done !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("lat4_read_latency", 64'(waited), 64'd4);
        check_val("lat4_read_ValM", bus4.ValM, 64'h0);

        repeat (2) @(negedge clk);
        check_val("sb_leftover", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the Y86-64 SEQ datapath. Sits between execute and PC update / decode write-back.
- Selects the data-memory address and write data from icode.
- Performs an 8-byte little-endian read or write on an internal byte-addressed data memory.
- Returns ValM to PC_update (ret) and decode_wb (mrmovq/popq).
- Produces the architectural status code.
- Has a start/done handshake with configurable latency, so it can later be reused in the pipelined core.

Parameters:
DEPTH, 1024, data-memory size in bytes.
LAT, 1, cycles from start sampled to done asserted (legal range 1..15).

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request pulse; inputs sampled on the same edge
icode  in  4  instruction code from fetch
ValE  in  64  execute result
ValA  in  64  register operand A from decode
ValP  in  64  incremented PC from fetch
instr_valid  in  1  fetch validity flag
imem_error  in  1  fetch address error flag
ValM  out  64  read data; holds until the next done
dmem_error  out  1  data address out of range for the last completed op
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
busy  out  1  high from the cycle after start through the done cycle
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: ValM=0, dmem_error=0, stat=1 (AOK), busy=0, done=0, FSM=IDLE, counter=0. Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT.
  - IDLE: when start=1, latch icode, ValE, ValA, ValP, instr_valid and imem_error; load counter=LAT-1; go to WAIT.
  - WAIT: if counter==0, complete the operation (assert done for one cycle, update outputs) and return to IDLE. Otherwise decrement the counter.
  - With LAT=1, done is asserted one cycle after the start edge.
- start while busy (WAIT state) is ignored; there is no queueing.
- Address select:
  - rmmovq(4), mrmovq(5), call(8), pushq(A): address = ValE.
  - ret(9), popq(B): address = ValA.
- Write ops and data:
  - rmmovq, pushq write ValA.
  - call writes ValP.
- Read ops: mrmovq, ret, popq. ValM = mem[addr] (LSB) .. mem[addr+7] (MSB).
- Any other icode: no access; ValM updated to 0 at done.
- Range check: error iff addr > DEPTH-8, compared on the full 64-bit unsigned value, so addresses near 2^64 cannot wrap.
  - On error: dmem_error=1, no write, ValM=0.
  - The check applies only to memory icodes.
- Write commits on the done edge only. No partial writes.
- Read of never-written bytes returns 0 (the memory initialises to 0 at time zero).
- stat priority at done:
  1. imem_error → ADR (3)
  2. !instr_valid → INS (4)
  3. dmem_error → ADR (3)
  4. icode==0 → HLT (2)
  5. otherwise AOK (1)
- If imem_error or !instr_valid is latched, the memory access is suppressed: no write, ValM=0.
- Reset during WAIT: abort immediately with no write; all outputs return to reset values the next cycle.
- reset and start in the same cycle: reset wins; the request is dropped.
- Outputs change only at done or reset; they are stable in all other cycles.

Decomposition:
- Shared package y86_pkg:
  - icode constants: IHALT=0, INOP=1, ICMOVXX=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - stat constants: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - FSM state type.
- One sub-module, data_mem: byte array of DEPTH bytes with a combinational 8-byte little-endian read and a synchronous 8-byte write enable.

Test Plan:
- rmmovq icode=4, ValE=2, ValA=120, start; then mrmovq icode=5, ValE=2, start → second done has ValM=120, stat=1, dmem_error=0.
- pushq icode=A, ValE=0x1F8, ValA=0xDEADBEEF; then popq icode=B, ValA=0x1F8 → ValM=0xDEADBEEF. Also call icode=8, ValE=0x1F0, ValP=55; then ret icode=9, ValA=0x1F0 → ValM=55.
- Range errors:
  - mrmovq ValE=1017 with DEPTH=1024 → dmem_error=1, stat=3, ValM=0.
  - rmmovq ValE=0xFFFFFFFFFFFFFFFC → error and no memory change (readback of addr 0 is unchanged).
- LAT=4: start at cycle 0 → done exactly at cycle 4 and busy high for cycles 1-4. A second start at cycle 2 is ignored (exactly one done).
- Reset asserted during WAIT of rmmovq ValE=8, ValA=5 → no done, outputs zero/AOK; a subsequent read of addr 8 returns 0.
- Status codes:
  - icode=0 → stat=2.
  - instr_valid=0 with rmmovq → stat=4 and no write.
  - imem_error=1 → stat=3.
